// File: rtl/mux4_arb_pkg.sv
// rtl/mux4_arb_pkg.sv - shared types and constants for the 4-way round-robin arbiter
package mux4_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int REQ_NUM = 4;
    localparam int SEL_W   = 2;

endpackage

// File: rtl/mux4to1_n.sv
// rtl/mux4to1_n.sv - 4:1 mux of N-bit words
module mux4to1_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] data_i [0:3],
    input  logic [1:0]   sel_i,
    output logic [N-1:0] data_o
);

    // Pure select; the arbiter registers the result
    always_comb begin
        data_o = data_i[sel_i];
    end

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [REQ_NUM-1:0] req,
    input  logic [SEL_W-1:0]   prio,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    // Scan from the farthest offset back to prio so the nearest set bit wins last
    always_comb begin
        logic [SEL_W-1:0] idx;
        winner = '0;
        idx    = '0;
        any    = |req;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            idx = prio + SEL_W'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter_n.sv
// rtl/mux4_rr_arbiter_n.sv - packet round-robin arbiter driving a shared 4:1 mux with a registered output stage
module mux4_rr_arbiter_n
    import mux4_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [N-1:0]       data_i [0:3],
    input  logic [REQ_NUM-1:0] last_i,
    output logic [REQ_NUM-1:0] ready_o,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [N-1:0]       data_o,
    output logic               last_o,
    output logic [SEL_W-1:0]   src_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               busy_o
);

    localparam int BCW = $clog2(MAX_BURST) + 1;

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] prio_q, prio_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     data_q, data_d;
    logic             last_q, last_d;
    logic [SEL_W-1:0] src_q, src_d;

    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic [N-1:0]     mux_data;
    logic             out_free;
    logic             accept;
    logic             beat_last;

    rr_pick4 u_pick (
        .req    (req_i),
        .prio   (prio_q),
        .winner (winner),
        .any    (any_req)
    );

    mux4to1_n #(.N(N)) u_mux (
        .data_i (data_i),
        .sel_i  (sel_o),
        .data_o (mux_data)
    );

    assign sel_o   = grant_q;
    assign busy_o  = (state_q == BURST);
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign src_o   = src_q;

    // Grant sequencing, beat counting and the one-entry output register
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        src_d      = src_q;
        ready_o    = '0;

        out_free  = !valid_q || ready_i;
        if (state_q == BURST) begin
            ready_o[grant_q] = out_free;
        end
        accept    = (state_q == BURST) && req_i[grant_q] && out_free;
        // Forced release keeps one requester from starving the others
        beat_last = last_i[grant_q] || (beat_cnt_q == BCW'(MAX_BURST - 1));

        if (state_q == IDLE) begin
            if (any_req) begin
                grant_d    = winner;
                beat_cnt_d = '0;
                state_d    = BURST;
            end
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
            if (beat_last) begin
                state_d    = IDLE;
                prio_d     = grant_q + SEL_W'(1);
                beat_cnt_d = '0;
            end
        end

        // A new beat may overwrite one that drains in the same cycle
        if (accept) begin
            valid_d = 1'b1;
            data_d  = mux_data;
            last_d  = beat_last;
            src_d   = grant_q;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset drops any partial grant and the held beat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            prio_q     <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            src_q      <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            src_q      <= src_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter_n.sv
// tb/tb_mux4_rr_arbiter_n.sv - directed table-driven bench for mux4_rr_arbiter_n
module tb_mux4_rr_arbiter_n;

    localparam int N = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_i;
    logic [N-1:0] data_i [0:3];
    logic [3:0]   last_i;
    logic [3:0]   ready_o;
    logic         ready_i;
    logic         valid_o;
    logic [N-1:0] data_o;
    logic         last_o;
    logic [1:0]   src_o;
    logic [1:0]   sel_o;
    logic         busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    mux4_rr_arbiter_n #(.N(N), .MAX_BURST(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .src_o   (src_o),
        .sel_o   (sel_o),
        .busy_o  (busy_o)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic [5:0] dat;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_last;
        logic [1:0] e_src;
        logic [1:0] e_sel;
        logic       e_busy;
        logic [3:0] e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] last, logic [5:0] dat, logic rdy,
                                logic ev, logic [7:0] ed, logic el, logic [1:0] es, logic [1:0] esel,
                                logic eb, logic [3:0] er);
        vec_t v;
        v.rst = rst; v.req = req; v.last = last; v.dat = dat; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_src = es; v.e_sel = esel;
        v.e_busy = eb; v.e_ready = er;
        return v;
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] last, input logic [5:0] dat, input logic rdy);
        req_i   = req;
        last_i  = last;
        ready_i = rdy;
        for (int k = 0; k < 4; k++) data_i[k] = {2'(k), dat};
    endtask

    task automatic check_all(input string name, input logic ev, input logic [7:0] ed, input logic el,
                             input logic [1:0] es, input logic [1:0] esel, input logic eb, input logic [3:0] er);
        n_tests++;
        if ({valid_o, data_o, last_o, src_o, sel_o, busy_o, ready_o} !== {ev, ed, el, es, esel, eb, er}) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h l=%b src=%0d sel=%0d busy=%b rdy=%b, want v=%b d=%h l=%b src=%0d sel=%0d busy=%b rdy=%b",
                     name, valid_o, data_o, last_o, src_o, sel_o, busy_o, ready_o, ev, ed, el, es, esel, eb, er);
        end
    endtask

    initial begin
        // Seg A: single requester 2, three beats
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 6'h01, 1, 0, 8'h00, 0, 0, 2, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 6'h02, 1, 1, 8'h82, 0, 2, 2, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 6'h03, 1, 1, 8'h83, 0, 2, 2, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 6'h04, 1, 1, 8'h84, 1, 2, 2, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 6'h00, 1, 0, 8'h84, 1, 2, 2, 0, 4'b0000));
        // Seg B: all four, single-beat packets, order 0,1,2,3,0
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 6'h00, 1, 0, 8'h00, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 0, 8'h00, 0, 0, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 1, 8'h10, 1, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 0, 8'h10, 1, 0, 1, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 1, 8'h50, 1, 1, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 0, 8'h50, 1, 1, 2, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 1, 8'h90, 1, 2, 2, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 0, 8'h90, 1, 2, 3, 1, 4'b1000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 1, 8'hD0, 1, 3, 3, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 0, 8'hD0, 1, 3, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 6'h10, 1, 1, 8'h10, 1, 0, 0, 0, 4'b0000));
        // Seg C: reset mid-burst with valid_o=1, then scan restarts at 0
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 6'h05, 1, 0, 8'h10, 1, 0, 2, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 6'h05, 1, 1, 8'h85, 0, 2, 2, 1, 4'b0100));
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 6'h05, 1, 0, 8'h00, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 6'h06, 1, 0, 8'h00, 0, 0, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 4'b1001, 4'b1001, 6'h06, 1, 1, 8'h06, 1, 0, 0, 0, 4'b0000));
        // Seg D: requester 1 with 3 cycles of backpressure
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h11, 1, 0, 8'h06, 1, 0, 1, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h12, 1, 1, 8'h52, 0, 1, 1, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h13, 0, 1, 8'h52, 0, 1, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h14, 0, 1, 8'h52, 0, 1, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h15, 0, 1, 8'h52, 0, 1, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h16, 1, 1, 8'h56, 0, 1, 1, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 6'h17, 1, 1, 8'h57, 1, 1, 1, 0, 4'b0000));
        // Seg E: forced last at beat 8, requester 0 waiting
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h20, 1, 0, 8'h57, 1, 1, 1, 1, 4'b0010));
        for (int b = 1; b <= 8; b++)
            vecs.push_back(mk(0, 4'b0011, 4'b0000, 6'(6'h20 + b), 1, 1, 8'(8'h60 + b), (b == 8), 1, 1,
                              (b != 8), (b == 8) ? 4'b0000 : 4'b0010));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 6'h29, 1, 0, 8'h68, 1, 1, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 4'b0011, 4'b0001, 6'h29, 1, 1, 8'h29, 1, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h2A, 1, 0, 8'h29, 1, 0, 1, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 6'h2B, 1, 1, 8'h6B, 0, 1, 1, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 6'h2C, 1, 1, 8'h6C, 1, 1, 1, 0, 4'b0000));
        // Seg F: requester 3 lock while req 3 drops and req 0 waits
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 6'h30, 1, 0, 8'h6C, 1, 1, 3, 1, 4'b1000));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 6'h31, 1, 1, 8'hF1, 0, 3, 3, 1, 4'b1000));
        for (int b = 2; b <= 5; b++)
            vecs.push_back(mk(0, 4'b0001, 4'b0000, 6'(6'h30 + b), 1, 0, 8'hF1, 0, 3, 3, 1, 4'b1000));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 6'h36, 1, 1, 8'hF6, 0, 3, 3, 1, 4'b1000));
        vecs.push_back(mk(0, 4'b1001, 4'b1000, 6'h37, 1, 1, 8'hF7, 1, 3, 3, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 6'h38, 1, 0, 8'hF7, 1, 3, 0, 1, 4'b0001));

        // Power-on reset
        rst_i = 1'b1;
        drive(4'b0000, 4'b0000, 6'h00, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 check_all("reset", 0, 8'h00, 0, 0, 0, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            rst_i = vecs[i].rst;
            drive(vecs[i].req, vecs[i].last, vecs[i].dat, vecs[i].rdy);
            @(posedge clk_i);
            #1 check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_last,
                         vecs[i].e_src, vecs[i].e_sel, vecs[i].e_busy, vecs[i].e_ready);
        end

        // Asynchronous reset with no clock edge, while a beat is held mid-burst
        @(negedge clk_i);
        drive(4'b0001, 4'b0000, 6'h39, 1'b1);
        @(posedge clk_i);
        #1 check_all("pre_async", 1, 8'h39, 0, 0, 0, 1, 4'b0001);
        #2 rst_i = 1'b1;
        #1 check_all("async_rst", 0, 8'h00, 0, 0, 0, 0, 4'b0000);

        // Recovery: bounded wait for a single-beat packet from requester 2
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(4'b0100, 4'b0100, 6'h3A, 1'b1);
        begin
            int cyc;
            cyc = 0;
            while (!valid_o && cyc < 8) begin
                @(posedge clk_i);
                #1 cyc++;
            end
            n_tests++;
            if (!valid_o || cyc != 2) begin
                n_fail++;
                $display("FAIL recover_latency: got valid=%b after %0d cycles, want valid=1 after 2", valid_o, cyc);
            end
            check_all("recover_beat", 1, 8'hBA, 1, 2, 2, 0, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
